param_fifo: RTL



---
 rtl/noc_fifo_pkg.sv | 16 +
 rtl/fifo_ptr.sv | 19 +
 rtl/param_fifo.sv | 94 +++++++++
 3 files changed

// File: rtl/noc_fifo_pkg.sv
// Shared constants and helpers for the NoC buffer family: default flit width/depth
// and the log2 used to size pointers.
package noc_fifo_pkg;

    localparam int FLIT_WIDTH = 64;
    localparam int FIFO_DEPTH = 32;

    // Smallest r with 2**r >= n; exact for the power-of-two depths used here.
    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// (PW)-bit wrap-around pointer register; the MSB acts as the pass/wrap bit
// when PW = log2(DEPTH)+1.
module fifo_ptr #(
    parameter int PW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + PW'(1);
    end

endmodule

// File: rtl/param_fifo.sv
// Parametrised show-ahead circular FIFO with occupancy count and watermarks.
// Sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module param_fifo
    import noc_fifo_pkg::*;
#(
    parameter int WIDTH    = FLIT_WIDTH,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = log2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam int CW = AW + 1;
    localparam logic [AW:0] AF_LIM = CW'(AF_LEVEL);
    localparam logic [AW:0] AE_LIM = CW'(AE_LEVEL);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] mem [DEPTH];

    assign wr_acc = wr & ~full;
    assign rd_acc = rd & ~empty;

    fifo_ptr #(.PW(CW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.PW(CW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Status is derived purely from the registered pointers, never from wr/rd.
    assign empty        = (rd_ptr == wr_ptr);
    assign full         = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= AF_LIM);
    assign almost_empty = (count <= AE_LIM);
    assign dout         = mem[rd_ptr[AW-1:0]];

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr && full)
                ovf_q <= 1'b1;
            if (rd && empty)
                udf_q <= 1'b1;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
